// File: rtl/pump_lead_lag_ctrl.sv
// pump_lead_lag_ctrl: two-pump lead/lag fill scheduler with staggered start, min-on time and sensor fault.
// Define PUMP_LEAD_ROTATE_EN to alternate the lead pump on every completed fill.
module pump_lead_lag_ctrl #(
  parameter int MIN_ON    = 16,
  parameter int LAG_DELAY = 8,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic I,
  input  logic S,
  output logic P1,
  output logic P2,
  output logic lead,
  output logic fault
);
  typedef enum logic [1:0] {IDLE, LEAD, BOTH, FAULT} state_t;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] LAG_C = CNT_W'(LAG_DELAY);
  state_t state, state_nxt;
  logic [1:0] i_sync, s_sync;
  logic [CNT_W-1:0] run_cnt, dry_cnt, run_nxt, dry_nxt;
  logic is, ss, min_done, enter_lead, clr_run, lead_nxt;
  assign is = i_sync[1];
  assign ss = s_sync[1];
  assign min_done = run_cnt >= MIN_C;
  always_comb begin
    state_nxt = state;
    if (ss && !is) state_nxt = FAULT;
    else
      case (state)
        IDLE:  state_nxt = is ? IDLE : LEAD;
        LEAD:  state_nxt = (ss && min_done) ? IDLE : (!is && dry_cnt == LAG_C) ? BOTH : LEAD;
        BOTH:  state_nxt = !min_done ? BOTH : ss ? IDLE : is ? LEAD : BOTH;
        FAULT: state_nxt = ss ? FAULT : is ? IDLE : LEAD;
      endcase
  end
  assign enter_lead = state_nxt == LEAD && (state == IDLE || state == FAULT);
  assign clr_run = enter_lead || (state_nxt == BOTH && state == LEAD);
  assign run_nxt = clr_run ? '0 : min_done ? run_cnt : run_cnt + 1'b1;
  assign dry_nxt = (enter_lead || is) ? '0 : (state == LEAD && dry_cnt != LAG_C) ? dry_cnt + 1'b1 : dry_cnt;
`ifdef PUMP_LEAD_ROTATE_EN
  assign lead_nxt = lead ^ (state_nxt == IDLE && (state == LEAD || state == BOTH));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lead <= 1'b0;
    else lead <= lead_nxt;
`else
  assign lead_nxt = 1'b0;
  assign lead = 1'b0;
`endif
  // low sensor sync resets to wet so releasing reset never looks like a fill demand
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      i_sync  <= 2'b11;
      s_sync  <= 2'b00;
      state   <= IDLE;
      run_cnt <= '0;
      dry_cnt <= '0;
      P1      <= 1'b0;
      P2      <= 1'b0;
      fault   <= 1'b0;
    end else begin
      i_sync  <= {i_sync[0], I};
      s_sync  <= {s_sync[0], S};
      state   <= state_nxt;
      run_cnt <= run_nxt;
      dry_cnt <= dry_nxt;
      P1      <= state_nxt == BOTH || (state_nxt == LEAD && !lead_nxt);
      P2      <= state_nxt == BOTH || (state_nxt == LEAD && lead_nxt);
      fault   <= state_nxt == FAULT;
    end
endmodule

// File: tb/tb_pump_lead_lag_ctrl.sv
// tb_pump_lead_lag_ctrl: directed scoreboard bench for pump_lead_lag_ctrl (MIN_ON=4, LAG_DELAY=3).
module tb_pump_lead_lag_ctrl;
  logic clk = 1'b0;
  logic reset_n, I, S, P1, P2, lead, fault;
  logic [3:0] obs;
  typedef struct { int due; string tag; logic [3:0] exp; } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit ld = 1'b0;
`ifdef PUMP_LEAD_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  pump_lead_lag_ctrl #(.MIN_ON(4), .LAG_DELAY(3), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .I(I), .S(S),
    .P1(P1), .P2(P2), .lead(lead), .fault(fault)
  );
  assign obs = {P1, P2, fault, lead};
  always #5 clk = ~clk;
  // expected {P1,P2,fault,lead} from lead/lag pump roles and the current lead
  function automatic logic [3:0] ex(bit lead_on, bit lag_on, bit f, bit l);
    return l ? {lag_on, lead_on, f, l} : {lead_on, lag_on, f, l};
  endfunction
  task automatic expect_in(int n, string tag, logic [3:0] e);
    q.push_back('{cyc + n, tag, e});
  endtask
  task automatic check_due();
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s: {P1,P2,fault,lead} observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask
  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      check_due();
    end
  endtask
  initial begin
    reset_n = 1'b0; I = 1'b1; S = 1'b1;
    #2;
    expect_in(0, "reset", 4'b0000);
    check_due();
    expect_in(2, "reset_hold", 4'b0000);
    run(2);
    reset_n = 1'b1; S = 1'b0;
    expect_in(5, "idle_after_release", 4'b0000);
    run(5);
    // fill A: short demand, high sensor arrives early so min-on holds the pump
    I = 1'b0;
    expect_in(2, "a_pre", ex(0, 0, 0, ld));
    expect_in(3, "a_lead_on", ex(1, 0, 0, ld));
    run(1);
    I = 1'b1; S = 1'b1;
    expect_in(3, "a_min_hold1", ex(1, 0, 0, ld));
    expect_in(6, "a_min_hold4", ex(1, 0, 0, ld));
    ld ^= ROT;
    expect_in(7, "a_stop", ex(0, 0, 0, ld));
    run(7);
    S = 1'b0;
    expect_in(3, "a_idle", ex(0, 0, 0, ld));
    run(3);
    // fill B: staggered lag start, lag drop, then stop on high level
    I = 1'b0;
    expect_in(2, "b_pre", ex(0, 0, 0, ld));
    expect_in(3, "b_lead_on", ex(1, 0, 0, ld));
    expect_in(6, "b_lag_pre", ex(1, 0, 0, ld));
    expect_in(7, "b_lag_on", ex(1, 1, 0, ld));
    run(12);
    I = 1'b1;
    expect_in(2, "b_lag_hold", ex(1, 1, 0, ld));
    expect_in(3, "b_lag_off", ex(1, 0, 0, ld));
    expect_in(6, "b_lead_stay", ex(1, 0, 0, ld));
    run(6);
    S = 1'b1;
    expect_in(2, "b_end_pre", ex(1, 0, 0, ld));
    ld ^= ROT;
    expect_in(3, "b_end", ex(0, 0, 0, ld));
    run(3);
    S = 1'b0;
    run(2);
    // fill C: inconsistent sensors while both pumps run
    I = 1'b0;
    expect_in(3, "c_lead_on", ex(1, 0, 0, ld));
    expect_in(7, "c_both", ex(1, 1, 0, ld));
    run(9);
    S = 1'b1;
    expect_in(2, "c_pre", ex(1, 1, 0, ld));
    expect_in(3, "c_fault", ex(0, 0, 1, ld));
    run(3);
    I = 1'b1; S = 1'b0;
    expect_in(2, "c_fault_hold", ex(0, 0, 1, ld));
    expect_in(3, "c_clear", ex(0, 0, 0, ld));
    expect_in(6, "c_idle", ex(0, 0, 0, ld));
    run(6);
    // fill D: asynchronous reset in the middle of BOTH
    I = 1'b0;
    expect_in(7, "d_both", ex(1, 1, 0, ld));
    run(8);
    #1;
    reset_n = 1'b0;
    #1;
    ld = 1'b0;
    expect_in(0, "d_async_rst", 4'b0000);
    check_due();
    run(2);
    reset_n = 1'b1;
    expect_in(2, "d_pre", 4'b0000);
    expect_in(3, "d_restart", ex(1, 0, 0, ld));
    expect_in(7, "d_restart_lag", ex(1, 1, 0, ld));
    run(7);
    n_cmp++;
    assert (q.size() == 0) else begin
      n_bad++;
      $error("FAIL pending: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
